// File: rtl/time_sync_ctrl.sv
// time_sync_ctrl: keeps a local HH:MM:SS clock and disciplines it against a
// remote time source. It sends an 'R' request over UART, then waits for the
// parser to report a frame. It retries on timeout and flags sync loss after
// repeated silence. Local time free-runs once it has been loaded.
module time_sync_ctrl #(
  parameter int CLK_HZ      = 50000000,
  parameter int RESYNC_S    = 60,
  parameter int TIMEOUT_CYC = 5000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_synced,
  input  logic [4:0] p_hour,
  input  logic [5:0] p_min,
  input  logic [5:0] p_sec,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       parser_clr,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       time_valid,
  output logic       sync_lost
);

  localparam int PW = (CLK_HZ > 1)      ? $clog2(CLK_HZ)        : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC)   : 1;
  localparam int RW = (RESYNC_S > 1)    ? $clog2(RESYNC_S)      : 1;
  localparam int NW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RESYNC_LAST = RW'(RESYNC_S - 1);
  localparam logic [NW-1:0] RETRY_MAX   = NW'(MAX_RETRY);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, RUN, LOST} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_tmo;
  logic [RW-1:0] r_resync;
  logic [NW-1:0] r_retry;
  logic          r_got;     // a frame was accepted while the request was in flight

  logic          w_acc;
  logic          w_tick;
  logic [NW-1:0] w_retry_nxt;

  assign w_acc       = p_synced && (p_hour < 5'd24) && (p_min < 6'd60) && (p_sec < 6'd60);
  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_retry_nxt = r_retry + NW'(1);

  // Seconds prescaler; an accepted frame realigns the second boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_presc <= '0;
    else if (w_acc || w_tick) r_presc <= '0;
    else                      r_presc <= r_presc + PW'(1);
  end

  // Local time: load from an accepted frame (wins over the tick), else advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour <= '0; min <= '0; sec <= '0; time_valid <= 1'b0;
    end else if (w_acc) begin
      hour <= p_hour; min <= p_min; sec <= p_sec; time_valid <= 1'b1;
    end else if (w_tick && time_valid) begin
      if (sec == 6'd59) begin
        sec <= '0;
        if (min == 6'd59) begin
          min  <= '0;
          hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        end else begin
          min <= min + 6'd1;
        end
      end else begin
        sec <= sec + 6'd1;
      end
    end
  end

  // Request/response FSM with timeout, retry and periodic resync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BOOT;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      parser_clr <= 1'b0;
      sync_lost  <= 1'b0;
      r_tmo      <= '0;
      r_resync   <= '0;
      r_retry    <= '0;
      r_got      <= 1'b0;
    end else begin
      parser_clr <= 1'b0;
      case (r_state)
        BOOT: r_state <= REQ;
        REQ: begin
          // First REQ cycle raises the request; it then holds until accepted.
          if (w_acc) r_got <= 1'b1;
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h52;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            r_tmo    <= '0;
            r_got    <= 1'b0;
            r_state  <= (r_got || w_acc) ? RUN : WAIT;
          end
        end
        WAIT: begin
          if (w_acc) begin
            r_state <= RUN;
          end else if (r_tmo == TMO_LAST) begin
            parser_clr <= 1'b1;
            r_tmo      <= '0;
            r_retry    <= w_retry_nxt;
            if (w_retry_nxt == RETRY_MAX) begin
              r_state   <= LOST;
              sync_lost <= 1'b1;
              r_resync  <= '0;
            end else begin
              r_state <= REQ;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        RUN: begin
          if (!w_acc && w_tick) begin
            if (r_resync == RESYNC_LAST) begin
              r_resync <= '0;
              r_state  <= REQ;
            end else begin
              r_resync <= r_resync + RW'(1);
            end
          end
        end
        LOST: begin
          if (w_acc) begin
            r_state <= RUN;
          end else if (w_tick) begin
            if (r_resync == RESYNC_LAST) begin
              r_resync <= '0;
              r_retry  <= '0;
              r_state  <= REQ;
            end else begin
              r_resync <= r_resync + RW'(1);
            end
          end
        end
        default: r_state <= BOOT;
      endcase
      // An accepted frame restarts all sync bookkeeping.
      if (w_acc) begin
        r_resync  <= '0;
        r_retry   <= '0;
        sync_lost <= 1'b0;
      end
    end
  end

endmodule
